fetch_stage: RTL and testbench

Instruction-fetch stage of the RV32I core. It holds the program counter and drives the address of the asynchronous instruction ROM. In the same cycle it captures the ROM's read data into the IF/ID pipeline register for the decoder. It handles sequential fetch, branch/jump redirects with flush, decode back-pressure, EBREAK halt and misaligned-target faults.

---
 rtl/fetch_if.sv | 27 ++
 rtl/fetch_stage.sv | 78 +++++++
 tb/tb_fetch_stage.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fetch_if.sv
// fetch_if: ROM, redirect and IF/ID signals between the fetch stage and its surroundings
interface fetch_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] instr_addr;
    logic [WIDTH-1:0] instr_rd;
    logic             id_stall;
    logic             redirect_en;
    logic [WIDTH-1:0] target_base;
    logic [WIDTH-1:0] target_offset;
    logic             target_clr_lsb;
    logic [WIDTH-1:0] id_instr;
    logic [WIDTH-1:0] id_pc;
    logic [WIDTH-1:0] id_pc_plus4;
    logic             id_valid;
    logic             halted;
    logic             fault;
    logic [WIDTH-1:0] fault_pc;
    modport master (
        output instr_addr, id_instr, id_pc, id_pc_plus4, id_valid, halted, fault, fault_pc,
        input  instr_rd, id_stall, redirect_en, target_base, target_offset, target_clr_lsb
    );
    modport slave (
        input  instr_addr, id_instr, id_pc, id_pc_plus4, id_valid, halted, fault, fault_pc,
        output instr_rd, id_stall, redirect_en, target_base, target_offset, target_clr_lsb
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction fetch with PC, IF/ID register, redirect/flush, stall, EBREAK halt and misaligned fault
module fetch_stage #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input logic     clk,
    input logic     rst,
    fetch_if.master f
);
    localparam logic [WIDTH-1:0] NOP    = WIDTH'(32'h0000_0013);
    localparam logic [WIDTH-1:0] EBREAK = WIDTH'(32'h0010_0073);
    typedef enum logic [1:0] {BOOT, RUN, HALT, FAULT} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d, instr_q, instr_d, id_pc_q, id_pc_d, id_pc4_q, id_pc4_d;
    logic [WIDTH-1:0] fault_pc_q, fault_pc_d, sum, target;
    logic             valid_q, valid_d;
    assign sum    = f.target_base + f.target_offset;
    assign target = {sum[WIDTH-1:1], sum[0] & ~f.target_clr_lsb};
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        id_pc_d    = id_pc_q;
        id_pc4_d   = id_pc4_q;
        valid_d    = valid_q;
        fault_pc_d = fault_pc_q;
        case (state_q)
            BOOT: state_d = RUN;
            RUN, HALT: begin
                if (f.redirect_en) begin
                    valid_d = 1'b0;
                    instr_d = NOP;
                    state_d = (target[1:0] == 2'b00) ? RUN : FAULT;
                    pc_d    = (target[1:0] == 2'b00) ? target : pc_q;
                    fault_pc_d = (target[1:0] == 2'b00) ? fault_pc_q : target;
                end else if (!f.id_stall && state_q == RUN) begin
                    instr_d  = f.instr_rd;
                    id_pc_d  = pc_q;
                    id_pc4_d = pc_q + WIDTH'(4);
                    valid_d  = 1'b1;
                    state_d  = (f.instr_rd == EBREAK) ? HALT : RUN;
                    pc_d     = (f.instr_rd == EBREAK) ? pc_q : pc_q + WIDTH'(4);
                end else if (!f.id_stall) begin
                    valid_d = 1'b0;
                    instr_d = NOP;
                end
            end
            default: valid_d = 1'b0;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            instr_q    <= NOP;
            id_pc_q    <= '0;
            id_pc4_q   <= '0;
            valid_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            id_pc_q    <= id_pc_d;
            id_pc4_q   <= id_pc4_d;
            valid_q    <= valid_d;
            fault_pc_q <= fault_pc_d;
        end
    end
    assign f.instr_addr  = pc_q;
    assign f.id_instr    = instr_q;
    assign f.id_pc       = id_pc_q;
    assign f.id_pc_plus4 = id_pc4_q;
    assign f.id_valid    = valid_q;
    assign f.halted      = (state_q == HALT);
    assign f.fault       = (state_q == FAULT);
    assign f.fault_pc    = fault_pc_q;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan scenarios plus random traffic checked against a behavioural fetch model
module tb_fetch_stage;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;
    logic [31:0] rom [0:63];
    fetch_if #(.WIDTH(32)) bus ();
    fetch_stage #(.WIDTH(32), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .f(bus));
    always #5 clk = ~clk;
    assign bus.instr_rd = rom[bus.instr_addr[7:2]];
    // behavioural model: mode 0=boot 1=run 2=halt 3=fault
    int          m_mode;
    logic [31:0] m_pc, m_instr, m_id_pc, m_id_pc4, m_fpc;
    logic        m_valid;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic model_step();
        logic [31:0] t, w;
        if (rst) begin
            m_mode = 0; m_pc = 0; m_instr = NOP; m_id_pc = 0; m_id_pc4 = 0; m_valid = 0; m_fpc = 0;
        end else if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 3) begin
            m_valid = 0;
        end else if (bus.redirect_en) begin
            t = bus.target_base + bus.target_offset;
            if (bus.target_clr_lsb) t = t & ~32'h1;
            m_valid = 0;
            m_instr = NOP;
            if (t % 4 == 0) begin m_pc = t; m_mode = 1; end
            else begin m_fpc = t; m_mode = 3; end
        end else if (bus.id_stall) begin
        end else if (m_mode == 1) begin
            w = rom[m_pc[7:2]];
            m_instr = w; m_id_pc = m_pc; m_id_pc4 = m_pc + 4; m_valid = 1;
            if (w == EBREAK) m_mode = 2;
            else m_pc = m_pc + 4;
        end else begin
            m_valid = 0;
            m_instr = NOP;
        end
    endtask
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        chk("instr_addr", bus.instr_addr, m_pc);
        chk("id_instr", bus.id_instr, m_instr);
        chk("id_pc", bus.id_pc, m_id_pc);
        chk("id_pc_plus4", bus.id_pc_plus4, m_id_pc4);
        chk("id_valid", 32'(bus.id_valid), 32'(m_valid));
        chk("halted", 32'(bus.halted), 32'(m_mode == 2));
        chk("fault", 32'(bus.fault), 32'(m_mode == 3));
        chk("fault_pc", bus.fault_pc, m_fpc);
    endtask
    task automatic redir(input logic [31:0] b, input logic [31:0] o, input logic c);
        bus.redirect_en = 1'b1; bus.target_base = b; bus.target_offset = o; bus.target_clr_lsb = c;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
    endtask
    initial begin
        for (int i = 0; i < 64; i++) rom[i] = {12'(i), 5'd1, 3'b000, 5'd1, 7'h13};
        bus.id_stall = 0; bus.redirect_en = 0; bus.target_base = 0; bus.target_offset = 0; bus.target_clr_lsb = 0;
        do_reset();
        chk("reset_instr", bus.id_instr, NOP);
        cycle();
        chk("boot_bubble", 32'(bus.id_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("seq_pc", bus.id_pc, 32'(4 * i));
        end
        bus.id_stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_addr", bus.instr_addr, 32'hC);
            chk("stall_idpc", bus.id_pc, 32'h8);
        end
        bus.id_stall = 0;
        cycle();
        chk("resume", bus.id_pc, 32'hC);
        cycle();
        redir(32'h10, -32'sd8, 0);
        cycle();
        chk("redir_addr", bus.instr_addr, 32'h8);
        bus.redirect_en = 0;
        cycle();
        chk("redir_target", bus.id_pc, 32'h8);
        redir(32'h40, 32'h0, 0);
        bus.id_stall = 1;
        cycle();
        chk("redir_beats_stall", bus.instr_addr, 32'h40);
        bus.id_stall = 0;
        redir(32'h21, 32'h2, 1);
        cycle();
        chk("jalr_fault_pc", bus.fault_pc, 32'h22);
        redir(32'h0, 32'h0, 0);
        for (int i = 0; i < 3; i++) cycle();
        chk("fault_sticky", 32'(bus.fault), 1);
        bus.id_stall = 1;
        rst = 1;
        cycle();
        chk("rst_over_redir", bus.instr_addr, 32'h0);
        rst = 0; bus.redirect_en = 0; bus.id_stall = 0;
        rom[3] = EBREAK;
        do_reset();
        for (int i = 0; i < 5; i++) cycle();
        chk("ebreak_captured", bus.id_instr, EBREAK);
        chk("halted_set", 32'(bus.halted), 1);
        for (int i = 0; i < 2; i++) cycle();
        chk("halt_pc", bus.instr_addr, 32'hC);
        redir(32'h40, 32'h0, 0);
        cycle();
        chk("halt_cleared", 32'(bus.halted), 0);
        bus.redirect_en = 0;
        cycle();
        chk("halt_resume", bus.id_pc, 32'h40);
        redir(32'hFFFF_FFF0, 32'hC, 0);
        cycle();
        bus.redirect_en = 0;
        cycle();
        chk("wrap", bus.instr_addr, 32'h0);
        for (int i = 0; i < 64; i++) rom[i] = ($urandom_range(0, 15) == 0) ? EBREAK : $urandom;
        for (int n = 0; n < 2000; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            bus.id_stall = ($urandom_range(0, 4) == 0);
            bus.redirect_en = ($urandom_range(0, 7) == 0);
            bus.target_base = 32'($urandom_range(0, 63) * 4) + (($urandom_range(0, 9) == 0) ? 32'($urandom_range(1, 3)) : 32'h0);
            bus.target_offset = 32'(4 * $urandom_range(0, 16)) - 32'd32;
            bus.target_clr_lsb = $urandom_range(0, 1);
            cycle();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
